// File: rtl/shift_arbiter.sv
// Round-robin front end for one shared combinational barrel shifter: grants one of
// two requesters, holds its operands on the shifter for SETTLE_CYCLES, returns the result.
module shift_arbiter #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_logical,
    input  logic             req0_right,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_logical,
    input  logic             req1_right,
    output logic [WIDTH-1:0] sh_a,
    output logic [WIDTH-1:0] sh_b,
    output logic             sh_ctl0,
    output logic             sh_ctl1,
    input  logic [WIDTH-1:0] sh_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id
);
    localparam int CNT_W = $clog2(SETTLE_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               id_q, id_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sh_a_q, sh_a_d;
    logic [WIDTH-1:0]   sh_b_q, sh_b_d;
    logic               sh_ctl0_q, sh_ctl0_d;
    logic               sh_ctl1_q, sh_ctl1_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic               rsp_id_q, rsp_id_d;
    logic               grant;

    // Only the low five bits of the shift amount reach the shifter.
    logic unused_b_bits;
    assign unused_b_bits = ^{req0_b[WIDTH-1:5], req1_b[WIDTH-1:5]};

    // Ties go to the requester that did not own the previous operation.
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else begin
            grant = req1_valid;
        end
    end

    // Ready is forced low while reset is held so every output reads 0 in reset.
    assign req0_ready = rst_n && (state_q == IDLE) && !grant && req0_valid;
    assign req1_ready = rst_n && (state_q == IDLE) &&  grant && req1_valid;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        cnt_d        = cnt_q;
        sh_a_d       = sh_a_q;
        sh_b_d       = sh_b_q;
        sh_ctl0_d    = sh_ctl0_q;
        sh_ctl1_d    = sh_ctl1_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        case (state_q)
            IDLE: begin
                if (req0_ready || req1_ready) begin
                    sh_a_d    = grant ? req1_a : req0_a;
                    sh_b_d    = {{(WIDTH-5){1'b0}}, (grant ? req1_b[4:0] : req0_b[4:0])};
                    sh_ctl0_d = grant ? req1_logical : req0_logical;
                    sh_ctl1_d = grant ? req1_right : req0_right;
                    id_d      = grant;
                    cnt_d     = CNT_W'(SETTLE_CYCLES - 1);
                    state_d   = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    rsp_data_d  = sh_out;
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d  = 1'b0;
                    last_grant_d = id_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            cnt_q        <= '0;
            sh_a_q       <= '0;
            sh_b_q       <= '0;
            sh_ctl0_q    <= 1'b0;
            sh_ctl1_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_id_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            cnt_q        <= cnt_d;
            sh_a_q       <= sh_a_d;
            sh_b_q       <= sh_b_d;
            sh_ctl0_q    <= sh_ctl0_d;
            sh_ctl1_q    <= sh_ctl1_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    assign sh_a      = sh_a_q;
    assign sh_b      = sh_b_q;
    assign sh_ctl0   = sh_ctl0_q;
    assign sh_ctl1   = sh_ctl1_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

endmodule
